mips_regfile_param: RTL and testbench

Parametrised MIPS general-purpose register file for the single-cycle and pipelined datapaths. It provides two combinational read ports and one write port, with write-to-read bypass and an optional hardwired-zero register 0. An asynchronous active-low reset clears the array. A sequential dump engine streams the whole register contents out one word per cycle for the testbench and debug host. This engine replaces file-based register dumping.

---
 rtl/mips_regfile_param.sv | 131 +++++++++++++
 tb/tb_mips_regfile_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_param.sv
// MIPS general-purpose register file: two combinational read ports with write bypass,
// one write port, optional hardwired zero register, and a one-word-per-cycle dump engine.
module mips_regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    input  logic              dump_start,
    output logic              dump_valid,
    output logic              dump_last,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data
);

    localparam int unsigned      N        = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } dump_state_e;

    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];

    dump_state_e       state_q, state_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_last_q, dump_last_d;
    logic [ADDR_W-1:0] dump_index_q, dump_index_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;

    logic              write_en;
    logic              load_word;

    assign write_en = signal_reg_write && !(ZERO_REG && write_reg == '0);

    // NOTE: every variable written in an always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[write_reg] = write_data;
        end
    end

    // Bypass lets a datapath read the value being written in the same cycle.
    assign read_data_1 = (ZERO_REG && read_reg_1 == '0)                 ? '0         :
                         (signal_reg_write && write_reg == read_reg_1) ? write_data :
                                                                         regs_q[read_reg_1];
    assign read_data_2 = (ZERO_REG && read_reg_2 == '0)                 ? '0         :
                         (signal_reg_write && write_reg == read_reg_2) ? write_data :
                                                                         regs_q[read_reg_2];

    // The dump index register doubles as the word counter while in RUN. The FSM returns
    // to IDLE on the edge that loads the last index so a new dump can follow seamlessly.
    always_comb begin
        state_d      = state_q;
        dump_index_d = '0;
        dump_valid_d = 1'b0;
        dump_last_d  = 1'b0;
        dump_data_d  = '0;
        load_word    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d   = ST_RUN;
                    load_word = 1'b1;
                end
            end
            ST_RUN: begin
                dump_index_d = dump_index_q + IDX_ONE;
                load_word    = 1'b1;
                if (dump_index_d == IDX_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_word) begin
            dump_valid_d = 1'b1;
            dump_last_d  = (dump_index_d == IDX_LAST);
            dump_data_d  = (ZERO_REG && dump_index_d == '0) ? '0 : regs_q[dump_index_d];
        end
    end

    // NOTE: the whole array is reset because the register file must read as zero after
    // reset; this keeps it in flops rather than letting it map onto a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, which is what makes the dump show data committed before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            dump_index_q <= '0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            dump_index_q <= dump_index_d;
            dump_data_q  <= dump_data_d;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_last  = dump_last_q;
    assign dump_index = dump_index_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_mips_regfile_param.sv
// Self-checking bench: a 32x32 zero-register instance and an 8x16 plain instance share
// stimulus and are compared every cycle against an array-based behavioural model.
module tb_mips_regfile_param;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  rr1, rr2, wr;
    logic [31:0] wd;
    logic        we, ds;

    logic [31:0] rd1_a, rd2_a, dd_a;
    logic        dv_a, dl_a;
    logic [4:0]  di_a;
    logic [15:0] rd1_b, rd2_b, dd_b;
    logic        dv_b, dl_b;
    logic [2:0]  di_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .read_reg_1(rr1), .read_reg_2(rr2),
        .read_data_1(rd1_a), .read_data_2(rd2_a),
        .write_reg(wr), .write_data(wd), .signal_reg_write(we),
        .dump_start(ds), .dump_valid(dv_a), .dump_last(dl_a),
        .dump_index(di_a), .dump_data(dd_a)
    );

    mips_regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .read_reg_1(rr1[2:0]), .read_reg_2(rr2[2:0]),
        .read_data_1(rd1_b), .read_data_2(rd2_b),
        .write_reg(wr[2:0]), .write_data(wd[15:0]), .signal_reg_write(we),
        .dump_start(ds), .dump_valid(dv_b), .dump_last(dl_b),
        .dump_index(di_b), .dump_data(dd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register arrays plus the edge number at which each dump began.
    logic [31:0] mem_a [32];
    logic [15:0] mem_b [8];
    int          edge_n = 0;
    int          base_a = 0, base_b = 0;
    bit          has_a = 0, has_b = 0;
    bit          ev_a = 0, el_a = 0, ev_b = 0, el_b = 0;
    int          ei_a = 0, ei_b = 0;
    logic [31:0] ed_a = '0;
    logic [15:0] ed_b = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mem_a[i]) mem_a[i] = '0;
            foreach (mem_b[i]) mem_b[i] = '0;
            has_a = 0; has_b = 0;
            ev_a = 0; el_a = 0; ev_b = 0; el_b = 0;
        end else begin
            edge_n++;
            if (ds && (!has_a || edge_n >= base_a + 32)) begin
                has_a = 1; base_a = edge_n;
            end
            if (ds && (!has_b || edge_n >= base_b + 8)) begin
                has_b = 1; base_b = edge_n;
            end
            ei_a = edge_n - base_a;
            ev_a = has_a && ei_a < 32;
            el_a = ev_a && ei_a == 31;
            ed_a = '0;
            if (ev_a && ei_a != 0) ed_a = mem_a[ei_a[4:0]];
            ei_b = edge_n - base_b;
            ev_b = has_b && ei_b < 8;
            el_b = ev_b && ei_b == 7;
            ed_b = '0;
            if (ev_b) ed_b = mem_b[ei_b[2:0]];
            if (we && wr != 5'd0) mem_a[wr] = wd;
            if (we) mem_b[wr[2:0]] = wd[15:0];
        end
    end

    function automatic logic [31:0] exp_rd_a(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (we && wr == a) return wd;
        return mem_a[a];
    endfunction

    function automatic logic [15:0] exp_rd_b(input logic [2:0] a);
        if (we && wr[2:0] == a) return wd[15:0];
        return mem_b[a];
    endfunction

    always @(negedge clk) begin
        check("cmp_rd1_a", rd1_a, exp_rd_a(rr1));
        check("cmp_rd2_a", rd2_a, exp_rd_a(rr2));
        check("cmp_valid_a", 32'(dv_a), 32'(ev_a));
        check("cmp_last_a", 32'(dl_a), 32'(el_a));
        if (ev_a) begin
            check("cmp_index_a", 32'(di_a), 32'(ei_a));
            check("cmp_data_a", dd_a, ed_a);
        end
        check("cmp_rd1_b", 32'(rd1_b), 32'(exp_rd_b(rr1[2:0])));
        check("cmp_rd2_b", 32'(rd2_b), 32'(exp_rd_b(rr2[2:0])));
        check("cmp_valid_b", 32'(dv_b), 32'(ev_b));
        check("cmp_last_b", 32'(dl_b), 32'(el_b));
        if (ev_b) begin
            check("cmp_index_b", 32'(di_b), 32'(ei_b));
            check("cmp_data_b", 32'(dd_b), 32'(ed_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rr1 = '0; rr2 = '0; wr = '0; wd = '0; we = 1'b0; ds = 1'b0;

        // Reset asserted mid-cycle, then read two registers.
        #1 rst_n = 1'b0;
        rr1 = 5'd5; rr2 = 5'd31;
        #1;
        check("rst_rd1", rd1_a, 32'h0);
        check("rst_rd2", rd2_a, 32'h0);
        check("rst_valid", 32'(dv_a), 32'h0);
        check("rst_index", 32'(di_a), 32'h0);
        check("rst_data", dd_a, 32'h0);
        check("rst_last", 32'(dl_a), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Write with same-cycle bypass, then read back from the array.
        wr = 5'd7; wd = 32'hDEADBEEF; we = 1'b1; rr1 = 5'd7;
        #1;
        check("bypass_a", rd1_a, 32'hDEADBEEF);
        check("bypass_b", 32'(rd1_b), 32'h0000BEEF);
        step();
        we = 1'b0;
        #1;
        check("stored_a", rd1_a, 32'hDEADBEEF);
        check("stored_b", 32'(rd1_b), 32'h0000BEEF);

        // Register 0: hardwired in instance A, ordinary in instance B.
        wr = 5'd0; wd = 32'h12345678; we = 1'b1; rr1 = 5'd0; rr2 = 5'd0;
        #1;
        check("zero_bypass_a", rd1_a, 32'h0);
        check("zero_bypass_a2", rd2_a, 32'h0);
        check("zero_bypass_b", 32'(rd1_b), 32'h00005678);
        step();
        we = 1'b0;
        #1;
        check("zero_stored_a", rd1_a, 32'h0);
        check("zero_stored_b", 32'(rd1_b), 32'h00005678);

        // Preload k*3 and run a full dump with an ignored mid-dump start pulse.
        for (int k = 0; k < 32; k++) begin
            wr = 5'(k); wd = 32'(k * 3); we = 1'b1;
            step();
        end
        we = 1'b0;
        ds = 1'b1;
        step();
        for (int k = 0; k < 32; k++) begin
            ds = (k == 5);
            check("dump_valid", 32'(dv_a), 32'h1);
            check("dump_index", 32'(di_a), 32'(k));
            check("dump_data", dd_a, (k == 0) ? 32'h0 : 32'(k * 3));
            check("dump_last", 32'(dl_a), 32'(k == 31));
            step();
        end
        ds = 1'b0;
        check("dump_done", 32'(dv_a), 32'h0);

        // Writes colliding with an ongoing dump.
        ds = 1'b1;
        step();
        ds = 1'b0;
        repeat (9) step();
        wr = 5'd10; wd = 32'h0000AAAA; we = 1'b1;
        step();
        we = 1'b0;
        check("collide_index", 32'(di_a), 32'd10);
        check("collide_old", dd_a, 32'd30);
        step();
        step();
        wr = 5'd20; wd = 32'h00005555; we = 1'b1;
        step();
        we = 1'b0;
        repeat (7) step();
        check("ahead_index", 32'(di_a), 32'd20);
        check("ahead_new", dd_a, 32'h00005555);
        repeat (12) step();
        rr1 = 5'd10;
        #1;
        check("collide_stored", rd1_a, 32'h0000AAAA);

        // Reset in the middle of a dump, then dump the cleared array.
        ds = 1'b1;
        step();
        ds = 1'b0;
        repeat (15) step();
        check("pre_rst_index", 32'(di_a), 32'd15);
        #1 rst_n = 1'b0;
        rr1 = 5'd15; rr2 = 5'd10; we = 1'b0;
        #1;
        check("mid_rst_valid", 32'(dv_a), 32'h0);
        check("mid_rst_last", 32'(dl_a), 32'h0);
        check("mid_rst_index", 32'(di_a), 32'h0);
        check("mid_rst_data", dd_a, 32'h0);
        check("mid_rst_rd1", rd1_a, 32'h0);
        check("mid_rst_rd2", rd2_a, 32'h0);
        check("mid_rst_valid_b", 32'(dv_b), 32'h0);
        step();
        rst_n = 1'b1;
        ds = 1'b1;
        step();
        ds = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("zero_dump_valid", 32'(dv_a), 32'h1);
            check("zero_dump_index", 32'(di_a), 32'(k));
            check("zero_dump_data", dd_a, 32'h0);
            step();
        end

        // Randomised traffic with occasional dumps and resets.
        repeat (1500) begin
            wr  = 5'($urandom);
            wd  = $urandom;
            we  = 1'($urandom_range(0, 1));
            rr1 = ($urandom_range(0, 1) == 0) ? wr : 5'($urandom);
            rr2 = ($urandom_range(0, 3) == 0) ? rr1 : 5'($urandom);
            ds  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end
        we = 1'b0;
        ds = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
